// File: rtl/uart_rx_filter.sv
// uart_rx_filter: 16x-oversampled 8N1 UART receiver with 2-bit address filter.
// Bytes whose bits [7:6] equal my_id are presented on data with a one-cycle
// valid strobe; all other well-framed bytes are dropped silently.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous, active-high
//   Rx         asynchronous serial input, idle high
//   my_id      local address, compared at the stop-bit decision
//   data       last accepted byte (held between valid pulses)
//   valid      one-cycle pulse when data updates
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high whenever the receiver is not idle
module uart_rx_filter #(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned BAUD          = 9600,
    parameter int unsigned CLKS_PER_TICK = CLK_FREQ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Rx,
    input  logic [1:0] my_id,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int unsigned OS_W   = 4;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state, state_d;
    logic                rx_meta, rx_sync;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tick;
    logic [OS_W-1:0]     os_cnt, os_d;
    logic [IDX_W-1:0]    bit_idx, bit_idx_d;
    logic [BYTE_W-1:0]   shreg, shreg_d;
    logic [BYTE_W-1:0]   data_d;
    logic                valid_d, frame_err_d;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // Oversample tick generator; held at zero in IDLE so the first tick of a
    // frame lands a full tick period after the start edge is seen.
    assign tick = (tick_cnt == TICK_W'(CLKS_PER_TICK - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            os_cnt    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            os_cnt    <= os_d;
            bit_idx   <= bit_idx_d;
            shreg     <= shreg_d;
            data      <= data_d;
            valid     <= valid_d;
            frame_err <= frame_err_d;
            busy      <= (state_d != IDLE);
        end
    end

    // Next-state and output logic. Start bit is confirmed at tick 7 (its
    // centre); every later sample is 16 ticks on, i.e. at a bit centre.
    always_comb begin
        state_d     = state;
        os_d        = os_cnt;
        bit_idx_d   = bit_idx;
        shreg_d     = shreg;
        data_d      = data;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (tick) begin
            os_d = os_cnt + OS_W'(1);
        end

        case (state)
            IDLE: begin
                if (!rx_sync) begin
                    state_d = START;
                    os_d    = '0;
                end
            end
            START: begin
                if (tick && os_cnt == OS_W'(7)) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        os_d      = '0;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (tick && os_cnt == OS_W'(15)) begin
                    shreg_d   = {rx_sync, shreg[BYTE_W-1:1]};
                    bit_idx_d = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_W'(7)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && os_cnt == OS_W'(15)) begin
                    if (rx_sync) begin
                        state_d = IDLE;
                        if (shreg[7:6] == my_id) begin
                            data_d  = shreg;
                            valid_d = 1'b1;
                        end
                    end else begin
                        state_d     = WAIT_HIGH;
                        frame_err_d = 1'b1;
                    end
                end
            end
            WAIT_HIGH: begin
                // Line must return high before a new start edge is honoured.
                if (rx_sync) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_filter.sv
// tb_uart_rx_filter: directed and randomized frames checked against a
// frame-level model (accepted-byte queue, frame-error count, latency).
module tb_uart_rx_filter;

    localparam int TICK = 4;
    localparam int BIT  = TICK * 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [1:0] my_id;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx_filter #(
        .CLK_FREQ     (50_000_000),
        .BAUD         (9600),
        .CLKS_PER_TICK(TICK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Rx       (rx),
        .my_id    (my_id),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed behaviour, collected on the falling edge.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    int         hold_viol = 0;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            last_data = 8'h00;
        end else begin
            if (valid) begin
                got_q.push_back(data);
                got_cyc.push_back(cyc);
                last_data = data;
            end else if (data !== last_data) begin
                hold_viol++;
            end
            if (frame_err) err_cnt++;
            if (valid && frame_err) both_cnt++;
        end
    end

    // Reference model state.
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    int         vi       = 0;
    int         last_c0  = 0;
    logic       busy_low = 1'b0;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        wait_clks(n * BIT);
    endtask

    // Sends one frame. stop_low = 0 gives a good stop bit; otherwise the
    // line is held low for stop_low bit times starting at the stop bit.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        if (stop_low == 0 && b[7:6] == my_id) exp_q.push_back(b);
        if (stop_low != 0) exp_err++;
        rx = 1'b0;
        last_c0 = cyc;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT);
        end
        if (stop_low == 0) begin
            rx = 1'b1;
            wait_clks(BIT);
        end else begin
            rx = 1'b0;
            wait_clks(stop_low * BIT);
            busy_low = busy;
            rx = 1'b1;
        end
    endtask

    task automatic verify(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = vi; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, " byte"}, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        vi = exp_q.size();
        check({tag, " frame_err count"}, err_cnt, exp_err);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        rx    = 1'b1;
        my_id = 2'b00;
        wait_clks(3);
        check("reset data", {24'h0, data}, 32'h0);
        check("reset valid", {31'h0, valid}, 32'h0);
        check("reset frame_err", {31'h0, frame_err}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        idle_bits(1);

        // Basic accept and latency from start edge to valid.
        my_id = 2'b10;
        send_frame(8'h85, 0);
        verify("frame 85");
        if (got_cyc.size() > 0)
            check("valid latency", got_cyc[0] - last_c0, BIT * 19 / 2 + 3);
        else
            check("valid latency", 0, BIT * 19 / 2 + 3);

        // Address mismatch: dropped, data held.
        send_frame(8'h45, 0);
        verify("frame 45");
        check("data held 85", {24'h0, data}, 32'h85);
        check("busy after 45", {31'h0, busy}, 32'h0);

        // Short low glitch on the idle line is rejected.
        rx = 1'b0;
        wait_clks(BIT * 3 / 8);
        idle_bits(2);
        verify("glitch");
        check("busy after glitch", {31'h0, busy}, 32'h0);
        my_id = 2'b11;
        send_frame(8'hC3, 0);
        verify("frame C3");
        check("data C3", {24'h0, data}, 32'hC3);

        // Bad stop bit with line held low.
        my_id = 2'b10;
        send_frame(8'h81, 3);
        check("busy while low", {31'h0, busy_low}, 32'h1);
        wait_clks(4);
        check("busy after release", {31'h0, busy}, 32'h0);
        idle_bits(1);
        send_frame(8'h9A, 0);
        verify("frame err then 9A");

        // Reset during data bit 4.
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'(i & 1);
            wait_clks(BIT);
        end
        rx = 1'b1;
        wait_clks(BIT / 2);
        reset = 1'b1;
        #1;
        check("midframe reset data", {24'h0, data}, 32'h0);
        check("midframe reset valid", {31'h0, valid}, 32'h0);
        check("midframe reset busy", {31'h0, busy}, 32'h0);
        wait_clks(4);
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'hBE, 0);
        verify("frame BE after reset");

        // Back-to-back frames.
        send_frame(8'h80, 0);
        send_frame(8'h8F, 0);
        send_frame(8'hBF, 0);
        idle_bits(1);
        verify("back-to-back");

        // Randomized traffic.
        for (int k = 0; k < 25; k++) begin
            logic [7:0] b;
            int         kind;
            my_id = 2'($urandom_range(0, 3));
            b     = 8'($urandom);
            kind  = $urandom_range(0, 9);
            if (kind == 0) begin
                rx = 1'b0;
                wait_clks($urandom_range(1, 20));
                idle_bits(1);
            end
            if (kind >= 8) begin
                send_frame(b, $urandom_range(1, 3));
                idle_bits(1);
            end else begin
                send_frame(b, 0);
                base = $urandom_range(0, 2);
                if (base > 0) idle_bits(base);
            end
        end
        idle_bits(1);
        verify("random");
        if (exp_q.size() > 0)
            check("random final data", {24'h0, data}, {24'h0, exp_q[exp_q.size() - 1]});

        check("valid with frame_err", both_cnt, 0);
        check("data changed without valid", hold_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
